// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
//   Loads sprite pixel data from a byte stream into on-chip sprite RAM and
//   serves a registered (x, y, sprite) read port with the same 2-bit codes
//   the display ROMs use (0 transparent, 1 outline, 2 body, 3 reserved).
//
//   Frame: SYNC_BYTE, sprite id, then ceil(SPRITE_W*SPRITE_H/4) data bytes,
//   four pixels per byte, LSB pair first, raster order.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_data, i_valid, o_ready valid/ready byte stream
//   o_busy                  frame in progress (id accepted, not yet done)
//   o_done                  one-cycle pulse: sprite fully written
//   o_err                   one-cycle pulse: sprite id out of range
//   i_rd_sprite/x/y         read address
//   o_rd_pixel              registered pixel code (0 when out of range)
module sprite_ram_loader #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 10,
  parameter int unsigned SPRITE_H    = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  input  logic [1:0] i_rd_sprite,
  input  logic [3:0] i_rd_x,
  input  logic [3:0] i_rd_y,
  output logic [1:0] o_rd_pixel
);

  localparam int unsigned PIX   = SPRITE_W * SPRITE_H;
  localparam int unsigned DEPTH = NUM_SPRITES * PIX;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW    = (PIX > 1) ? $clog2(PIX) : 1;

  localparam logic [AW-1:0] PIX_A    = AW'(PIX);
  localparam logic [NW-1:0] LAST_PIX = NW'(PIX - 1);
  localparam logic [7:0]    ID_LIMIT = 8'(NUM_SPRITES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_DATA,
    S_UNPACK,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] base;
  logic [NW-1:0] pix_idx;
  logic [1:0]    field;
  logic [7:0]    shreg;

  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

  logic [1:0]    mem [DEPTH];

  assign accept  = i_valid && o_ready;
  assign wr_en   = (state == S_UNPACK);
  assign wr_addr = base + AW'(pix_idx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      base    <= '0;
      pix_idx <= '0;
      field   <= '0;
      shreg   <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && i_data == SYNC_BYTE) state <= S_ID;
        end
        S_ID: begin
          if (accept) begin
            if (i_data >= ID_LIMIT) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              base    <= AW'(i_data) * PIX_A;
              pix_idx <= '0;
              o_busy  <= 1'b1;
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shreg   <= i_data;
            field   <= '0;
            o_ready <= 1'b0;
            state   <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          shreg   <= {2'b00, shreg[7:2]};
          field   <= field + 2'd1;
          pix_idx <= pix_idx + NW'(1);
          // Finishing the last pixel wins over the field count, so any
          // trailing fields of the final byte are never written.
          if (pix_idx == LAST_PIX) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else if (field == 2'd3) begin
            o_ready <= 1'b1;
            state   <= S_DATA;
          end
        end
        S_DONE: begin
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= shreg[1:0];
  end

  always_comb begin
    rd_ok   = (32'(i_rd_x) < SPRITE_W) && (32'(i_rd_y) < SPRITE_H) &&
              (32'(i_rd_sprite) < NUM_SPRITES);
    rd_addr = AW'(32'(i_rd_sprite) * PIX + 32'(i_rd_y) * SPRITE_W + 32'(i_rd_x));
  end

  // Read samples the pre-write RAM contents (read-before-write).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_rd_pixel <= '0;
    else       o_rd_pixel <= rd_ok ? mem[rd_addr] : '0;
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: a frame-level reference model
// predicts handshake/status outputs and RAM contents cycle by cycle.
module tb_sprite_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready, busy, done, err;
  logic [1:0] rd_sprite;
  logic [3:0] rd_x, rd_y;
  logic [1:0] rd_pixel;

  logic [7:0] d3;
  logic       v3;
  logic [1:0] s3;
  logic       ready3, busy3, done3, err3;
  logic [1:0] rd3_pixel;

  always #5 clk = ~clk;

  sprite_ram_loader u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_err(err),
    .i_rd_sprite(rd_sprite), .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_pixel(rd_pixel)
  );

  sprite_ram_loader #(.NUM_SPRITES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(d3), .i_valid(v3),
    .o_ready(ready3), .o_busy(busy3), .o_done(done3), .o_err(err3),
    .i_rd_sprite(s3), .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_pixel(rd3_pixel)
  );

  // ---------------- reference model (updated on rising edges) ----------------
  typedef struct { int t; int addr; int val; } wr_t;
  wr_t pend[$];
  int  mem_m [400];
  bit  known [400];
  int  cyc = 0, low_end = -10, done_cyc = -10, err_cyc = -10;
  int  pos = 0, k = 0, spr = 0;
  bit  m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int  m_rd = 0;
  bit  m_rd_known = 1'b1;

  always @(posedge clk) begin
    int a;
    cyc++;
    if (rst) begin
      pend.delete();
      pos = 0; m_ready = 1; m_busy = 0; m_done = 0; m_err = 0;
      low_end = -10; done_cyc = -10; err_cyc = -10;
      m_rd = 0; m_rd_known = 1;
    end else begin
      if (int'(rd_x) < 10 && int'(rd_y) < 10 && int'(rd_sprite) < 4) begin
        a = int'(rd_sprite) * 100 + int'(rd_y) * 10 + int'(rd_x);
        m_rd = mem_m[a]; m_rd_known = known[a];
      end else begin
        m_rd = 0; m_rd_known = 1;
      end
      while (pend.size() > 0 && pend[0].t == cyc) begin
        mem_m[pend[0].addr] = pend[0].val;
        known[pend[0].addr] = 1'b1;
        void'(pend.pop_front());
      end
      if (valid && m_ready) begin
        case (pos)
          0: if (data == 8'hA5) pos = 1;
          1: begin
            if (int'(data) >= 4) begin
              err_cyc = cyc; pos = 0;
            end else begin
              spr = int'(data); m_busy = 1; k = 0; pos = 2;
            end
          end
          default: begin
            for (int j = 0; j < 4; j++)
              if (4 * k + j < 100)
                pend.push_back('{cyc + 1 + j, spr * 100 + 4 * k + j, int'((data >> (2 * j)) & 8'h03)});
            if (k == 24) begin
              low_end = cyc + 4; done_cyc = cyc + 4; pos = 0;
            end else begin
              low_end = cyc + 3;
            end
            k++;
          end
        endcase
      end
      m_ready = !(cyc <= low_end);
      m_done  = (cyc == done_cyc);
      m_err   = (cyc == err_cyc);
      if (m_done) m_busy = 0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  int tcyc = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  bit rd_rand = 1'b1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    bit pre;
    pre = valid && ready;
    @(negedge clk);
    tcyc++;
    if (pre) acc_cnt++;
    if (!rst) begin
      chk("ready", int'(ready), int'(m_ready));
      chk("busy",  int'(busy),  int'(m_busy));
      chk("done",  int'(done),  int'(m_done));
      chk("err",   int'(err),   int'(m_err));
      if (m_rd_known) chk("rd_pixel", int'(rd_pixel), m_rd);
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
    if (rd_rand) begin
      rd_sprite = 2'($urandom);
      rd_x = 4'($urandom_range(0, 15));
      rd_y = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    bit r;
    if (gaps) repeat ($urandom_range(0, 2)) begin valid = 0; tick(); end
    data = b; valid = 1; guard = 0;
    do begin r = ready; tick(); guard++; end while (!r && guard < 200);
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 300) begin tick(); g++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic rd_check(input string nm, input int s, input int x, input int y, input int exp);
    rd_rand = 0;
    rd_sprite = 2'(s); rd_x = 4'(x); rd_y = 4'(y);
    tick();
    chk(nm, int'(rd_pixel), exp);
  endtask

  initial begin
    logic [7:0] fb [25];
    int t_first, d0, e0, a0, old;

    rst = 1; valid = 0; data = 0; v3 = 0; d3 = 0; s3 = 2'd3;
    rd_sprite = 0; rd_x = 0; rd_y = 0;
    tick(); tick();
    chk("rst_ready", int'(ready), 1); chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);   chk("rst_err", int'(err), 0);
    chk("rst_rd", int'(rd_pixel), 0);
    rst = 0;
    tick();

    // Fill every slot with random data; pixel 0 of sprite 0 avoids code 3.
    for (int s = 0; s < 4; s++) begin
      send_byte(8'hA5, 1); send_byte(8'(s), 1);
      for (int i = 0; i < 25; i++) begin
        fb[i] = 8'($urandom);
        if (s == 0 && i == 0) fb[i][1:0] = 2'($urandom_range(0, 2));
        send_byte(fb[i], 1);
      end
      valid = 0;
      wait_done();
      tick();
    end

    // Continuous valid, fixed pattern into sprite 1.
    d0 = done_cnt; a0 = acc_cnt;
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    t_first = 0;
    for (int i = 0; i < 25; i++) begin
      send_byte(8'b10_01_00_10, 0);
      if (i == 0) t_first = tcyc;
    end
    valid = 0;
    wait_done();
    chk("done_latency", tcyc - t_first, 124);
    repeat (3) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("bytes_consumed", acc_cnt - a0, 27);
    rd_check("s1_0_0", 1, 0, 0, 2);
    rd_check("s1_1_0", 1, 1, 0, 0);
    rd_check("s1_2_0", 1, 2, 0, 1);
    rd_check("s1_3_0", 1, 3, 0, 2);
    rd_check("s1_9_9", 1, 9, 9, 2);
    rd_rand = 1;

    // Out-of-range id, then a normal frame.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h07, 0);
    valid = 0;
    repeat (3) tick();
    chk("err_once", err_cnt - e0, 1);
    chk("err_no_done", done_cnt - d0, 0);
    rd_check("s1_after_err", 1, 1, 0, 0);
    rd_rand = 1;
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    for (int i = 0; i < 25; i++) send_byte(8'($urandom), 1);
    valid = 0;
    wait_done();
    tick();
    chk("done_after_err", done_cnt - d0, 1);

    // Junk before sync, all-3 sprite 0, read-before-write on pixel 0.
    old = mem_m[0];
    rd_rand = 0; rd_sprite = 0; rd_x = 0; rd_y = 0;
    send_byte(8'h00, 1); send_byte(8'h3C, 1); send_byte(8'hA5, 1); send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    tick(); chk("rbw_old", int'(rd_pixel), old);
    tick(); chk("rbw_new", int'(rd_pixel), 3);
    for (int i = 1; i < 25; i++) send_byte(8'hFF, 1);
    valid = 0;
    wait_done();
    for (int n = 0; n < 100; n++) rd_check("s0_all3", 0, n % 10, n / 10, 3);
    rd_rand = 1;

    // Partial frame interrupted by reset: sprite 2 zeroed, then 10 bytes of FF.
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    for (int i = 0; i < 25; i++) send_byte(8'h00, 1);
    valid = 0;
    wait_done();
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    for (int i = 0; i < 10; i++) send_byte(8'hFF, 1);
    valid = 0;
    repeat (6) tick();
    chk("busy_before_rst", int'(busy), 1);
    rst = 1;
    #1;
    chk("arst_ready", int'(ready), 1); chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);   chk("arst_err", int'(err), 0);
    chk("arst_rd", int'(rd_pixel), 0);
    tick(); tick();
    rst = 0;
    tick();
    rd_check("s2_pix0",  2, 0, 0, 3);
    rd_check("s2_pix39", 2, 9, 3, 3);
    rd_check("s2_pix40", 2, 0, 4, 0);
    rd_check("s2_pix99", 2, 9, 9, 0);

    // Out-of-range reads and a three-slot instance.
    rd_check("oor_x", 1, 10, 3, 0);
    rd_check("oor_y", 1, 3, 10, 0);
    rd_check("oor_max", 1, 15, 15, 0);
    chk("n3_sprite3", int'(rd3_pixel), 0);
    d3 = 8'hA5; v3 = 1; tick();
    d3 = 8'h03; tick();
    v3 = 0;
    chk("n3_err", int'(err3), 1);
    chk("n3_busy", int'(busy3), 0);
    rd_rand = 1;

    // Random frames: junk, valid and invalid ids, random gaps.
    for (int f = 0; f < 6; f++) begin
      int id;
      logic [7:0] junk;
      junk = 8'($urandom);
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk, 1);
      id = $urandom_range(0, 5);
      send_byte(8'hA5, 1); send_byte(8'(id), 1);
      if (id < 4) begin
        for (int i = 0; i < 25; i++) send_byte(8'($urandom), $urandom_range(0, 1) == 1);
        valid = 0;
        wait_done();
      end
      valid = 0;
      repeat (3) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
